// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: phase encoding, 640x480@60 timing defaults and phase-length helper.
package vga_timing_pkg;
   typedef enum logic [1:0] {
      PH_ACTIVE = 2'd0,
      PH_FRONT  = 2'd1,
      PH_SYNC   = 2'd2,
      PH_BACK   = 2'd3
   } phase_t;
   localparam int H_ACT_DEF  = 640;
   localparam int H_FP_DEF   = 16;
   localparam int H_SYNC_DEF = 96;
   localparam int H_BP_DEF   = 48;
   localparam int V_ACT_DEF  = 480;
   localparam int V_FP_DEF   = 10;
   localparam int V_SYNC_DEF = 2;
   localparam int V_BP_DEF   = 33;
   function automatic int phase_len(input phase_t ph, input int act, input int fp,
                                    input int sync, input int bp);
      return ph == PH_ACTIVE ? act : ph == PH_FRONT ? fp : ph == PH_SYNC ? sync : bp;
   endfunction
endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one raster axis; raw count plus ACTIVE->FRONT->SYNC->BACK phase FSM.
module vga_axis_counter import vga_timing_pkg::*; #(
   parameter int CW   = 12,
   parameter int ACT  = 640,
   parameter int FP   = 16,
   parameter int SYNC = 96,
   parameter int BP   = 48,
   parameter bit POL  = 1'b0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          adv,
   output logic [CW-1:0] cnt,
   output phase_t        phase,
   output logic          sync,
   output logic          wrap
);
   localparam int TOTAL = ACT + FP + SYNC + BP;
   logic [CW-1:0] cnt_q, cnt_d, len_q, len_d, len_last;
   phase_t        phase_q, phase_d;
   logic          sync_q, sync_d, last;
   always_comb begin
      len_last = CW'(phase_len(phase_q, ACT, FP, SYNC, BP) - 1);
      last     = len_q == len_last;
      wrap     = cnt_q == CW'(TOTAL - 1);
      cnt_d    = adv ? (wrap ? '0 : cnt_q + 1'b1) : cnt_q;
      len_d    = adv ? (last ? '0 : len_q + 1'b1) : len_q;
      phase_d  = (adv && last) ? phase_t'(phase_q + 2'd1) : phase_q;
      sync_d   = (phase_d == PH_SYNC) ? POL : !POL;
   end
   // Reset parks the axis on the last back-porch count so the first advance lands on 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q   <= CW'(TOTAL - 1);
         len_q   <= CW'(BP - 1);
         phase_q <= PH_BACK;
         sync_q  <= !POL;
      end else begin
         cnt_q   <= cnt_d;
         len_q   <= len_d;
         phase_q <= phase_d;
         sync_q  <= sync_d;
      end
   end
   assign cnt   = cnt_q;
   assign phase = phase_q;
   assign sync  = sync_q;
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster timing from a pix_en clock enable; sync, de, coordinates, strobes.
// Optional VGA_TIMING_FRAME_CNT_EN adds the 16-bit frame_cnt output.
module vga_timing_gen import vga_timing_pkg::*; #(
   parameter int CW     = 12,
   parameter int H_ACT  = H_ACT_DEF,
   parameter int H_FP   = H_FP_DEF,
   parameter int H_SYNC = H_SYNC_DEF,
   parameter int H_BP   = H_BP_DEF,
   parameter int V_ACT  = V_ACT_DEF,
   parameter int V_FP   = V_FP_DEF,
   parameter int V_SYNC = V_SYNC_DEF,
   parameter int V_BP   = V_BP_DEF,
   parameter bit HS_POL = 1'b0,
   parameter bit VS_POL = 1'b0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          pix_en,
   output logic          hsync,
   output logic          vsync,
   output logic          de,
   output logic [CW-1:0] x,
   output logic [CW-1:0] y,
   output logic          line_start,
   output logic          frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
   ,output logic [15:0]  frame_cnt
`endif
);
   logic [CW-1:0] h_cnt, v_cnt;
   phase_t        h_phase, v_phase;
   logic          h_sync, v_sync, h_wrap, v_wrap, v_adv;
   logic          x_act_n, y_act_n;
   logic          de_q, de_d, line_start_q, line_start_d, frame_start_q, frame_start_d;
   assign v_adv = pix_en & h_wrap;
   vga_axis_counter #(.CW(CW), .ACT(H_ACT), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(HS_POL)) u_h (
      .clk(clk), .rst(rst), .adv(pix_en),
      .cnt(h_cnt), .phase(h_phase), .sync(h_sync), .wrap(h_wrap)
   );
   vga_axis_counter #(.CW(CW), .ACT(V_ACT), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(VS_POL)) u_v (
      .clk(clk), .rst(rst), .adv(v_adv),
      .cnt(v_cnt), .phase(v_phase), .sync(v_sync), .wrap(v_wrap)
   );
   // de is registered from the next-state phases so it lines up with the new (x,y).
   always_comb begin
      x_act_n       = h_wrap || (h_phase == PH_ACTIVE && h_cnt != CW'(H_ACT - 1));
      y_act_n       = v_adv ? (v_wrap || (v_phase == PH_ACTIVE && v_cnt != CW'(V_ACT - 1)))
                            : v_phase == PH_ACTIVE;
      de_d          = pix_en ? (x_act_n && y_act_n) : de_q;
      line_start_d  = v_adv;
      frame_start_d = v_adv && v_wrap;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         de_q          <= 1'b0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         de_q          <= de_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
      end
   end
`ifdef VGA_TIMING_FRAME_CNT_EN
   logic [15:0] frame_cnt_q, frame_cnt_d;
   always_comb frame_cnt_d = frame_cnt_q + 16'(frame_start_d);
   always_ff @(posedge clk) begin
      if (rst) frame_cnt_q <= '0;
      else     frame_cnt_q <= frame_cnt_d;
   end
   assign frame_cnt = frame_cnt_q;
`endif
   assign hsync       = h_sync;
   assign vsync       = v_sync;
   assign de          = de_q;
   assign x           = h_cnt;
   assign y           = v_cnt;
   assign line_start  = line_start_q;
   assign frame_start = frame_start_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks on a 640x480 instance and a tiny-raster instance (16x12).
module tb_vga_timing_gen;
   logic        clk = 1'b0, rst = 1'b1, pix_en = 1'b0;
   logic        hs_d, vs_d, de_d, ls_d, fs_d, hs_s, vs_s, de_s, ls_s, fs_s;
   logic [11:0] x_d, y_d, x_s, y_s;
   int          checks = 0, errors = 0;
`ifdef VGA_TIMING_FRAME_CNT_EN
   logic [15:0] fc_d, fc_s;
`endif
   always #5 clk = ~clk;
   vga_timing_gen u_dut (
      .clk(clk), .rst(rst), .pix_en(pix_en), .hsync(hs_d), .vsync(vs_d), .de(de_d),
      .x(x_d), .y(y_d), .line_start(ls_d), .frame_start(fs_d)
`ifdef VGA_TIMING_FRAME_CNT_EN
      , .frame_cnt(fc_d)
`endif
   );
   // Tiny raster: H 8+2+3+3=16 (hsync x=10..12), V 6+2+2+2=12 (vsync y=8..9), 192 enables/frame.
   vga_timing_gen #(.H_ACT(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
                    .V_ACT(6), .V_FP(2), .V_SYNC(2), .V_BP(2)) u_sml (
      .clk(clk), .rst(rst), .pix_en(pix_en), .hsync(hs_s), .vsync(vs_s), .de(de_s),
      .x(x_s), .y(y_s), .line_start(ls_s), .frame_start(fs_s)
`ifdef VGA_TIMING_FRAME_CNT_EN
      , .frame_cnt(fc_s)
`endif
   );
   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask
   task automatic tick(input bit en);
      pix_en = en;
      @(posedge clk);
      #1;
   endtask
   initial begin
      int xe, p, fs_cnt;
      #1;
      repeat (3) tick(0);
      chk("rst_x", x_d, 799);
      chk("rst_y", y_d, 524);
      chk("rst_hs", hs_d, 1);
      chk("rst_vs", vs_d, 1);
      chk("rst_de", de_d, 0);
      chk("rst_ls", ls_d, 0);
      chk("rst_fs", fs_d, 0);
      rst = 1'b0;
      tick(1);
      chk("first_x", x_d, 0);
      chk("first_y", y_d, 0);
      chk("first_de", de_d, 1);
      chk("first_fs", fs_d, 1);
      chk("first_ls", ls_d, 1);
      chk("first_hs", hs_d, 1);
      chk("first_vs", vs_d, 1);
      for (int i = 1; i <= 800; i++) begin
         tick(1);
         xe = i % 800;
         if (xe inside {0, 639, 640, 655, 656, 751, 752}) begin
            chk("line_x", x_d, xe);
            chk("line_de", de_d, int'(xe < 640));
            chk("line_hs", hs_d, int'(!(xe >= 656 && xe <= 751)));
            chk("line_ls", ls_d, int'(xe == 0));
            chk("line_fs", fs_d, 0);
         end
         tick(0);
         if (xe == 0) chk("ls_clear", ls_d, 0);
      end
      chk("line_y", y_d, 1);
      repeat (300) tick(1);
      tick(0);
      chk("hold_ls0", ls_d, 0);
      repeat (49) tick(0);
      chk("hold_x", x_d, 300);
      chk("hold_y", y_d, 1);
      chk("hold_de", de_d, 1);
      chk("hold_hs", hs_d, 1);
      chk("hold_vs", vs_d, 1);
      chk("hold_ls", ls_d, 0);
      chk("hold_fs", fs_d, 0);
      rst = 1'b1;
      tick(0);
      rst = 1'b0;
      fs_cnt = 0;
      for (int i = 1; i <= 576; i++) begin
         tick(1);
         p = (i - 1) % 192;
         if (fs_s) fs_cnt++;
         if (p % 16 == 0) begin
            chk("frm_y", y_s, p / 16);
            chk("frm_vs", vs_s, int'(!(p / 16 == 8 || p / 16 == 9)));
            chk("frm_ls", ls_s, 1);
         end
         if (p == 11) chk("frm_hs", hs_s, 0);
      end
      chk("frm_starts", fs_cnt, 3);
      chk("big_x", x_d, 575);
      chk("big_de", de_d, 1);
`ifdef VGA_TIMING_FRAME_CNT_EN
      chk("frame_cnt", fc_s, 3);
      chk("frame_cnt_big", fc_d, 1);
`endif
      rst = 1'b1;
      tick(0);
      rst = 1'b0;
      repeat (159) tick(1);
      chk("mid_x", x_s, 14);
      chk("mid_y", y_s, 9);
      chk("mid_vs", vs_s, 0);
      rst = 1'b1;
      tick(0);
      chk("abort_vs", vs_s, 1);
      chk("abort_hs", hs_s, 1);
      chk("abort_de", de_s, 0);
      chk("abort_x", x_s, 15);
      chk("abort_y", y_s, 11);
      rst = 1'b0;
      tick(1);
      chk("restart_x", x_s, 0);
      chk("restart_y", y_s, 0);
      chk("restart_fs", fs_s, 1);
      chk("restart_de", de_s, 1);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
